// File: rtl/mux2_arb_ctrl.sv
// mux2_arb_ctrl: two-way round-robin arbiter driving the select pin of a
// shared MUX2_X1. Issues one-hot grants, a matching registered select, and
// bounds how long one owner may keep the mux while the other requester waits.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no grant; S holds its last value so Z does not glitch
// ST_OWN_A | A owns the mux (GNT_A=1, S=0)
// ST_OWN_B | B owns the mux (GNT_B=1, S=1)
module mux2_arb_ctrl #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             REQ_A,
  input  logic             REQ_B,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             S,
  output logic             VALID,
  output logic [CNT_W-1:0] HOLD_CNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  // Terminal count of the hold counter; also the preemption threshold.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cnt_at_max;
  logic             enter_own_a;
  logic             enter_own_b;
  logic             enter_own;

  assign cnt_at_max = (cnt_q == CNT_MAX);

  // Next-state selection: round-robin from idle, release or preempt when owned.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_A && REQ_B) begin
          state_d = (last_q == LAST_A) ? ST_OWN_B : ST_OWN_A;
        end else if (REQ_A) begin
          state_d = ST_OWN_A;
        end else if (REQ_B) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!REQ_A) begin
          state_d = REQ_B ? ST_OWN_B : ST_IDLE;
        end else if (REQ_B && cnt_at_max) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_B: begin
        if (!REQ_B) begin
          state_d = REQ_A ? ST_OWN_A : ST_IDLE;
        end else if (REQ_A && cnt_at_max) begin
          state_d = ST_OWN_A;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Edge-of-entry decode shared by the counter, LAST and select updates.
  always_comb begin
    enter_own_a = (state_d == ST_OWN_A) && (state_q != ST_OWN_A);
    enter_own_b = (state_d == ST_OWN_B) && (state_q != ST_OWN_B);
    enter_own   = enter_own_a || enter_own_b;
  end

  // Hold counter: restart on a new owner, count up while held, saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (enter_own) begin
      cnt_d = '0;
    end else if (!cnt_at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // LAST and select only move when a new grant is issued.
  always_comb begin
    last_d = last_q;
    s_d    = s_q;
    if (enter_own_a) begin
      last_d = LAST_A;
      s_d    = 1'b0;
    end else if (enter_own_b) begin
      last_d = LAST_B;
      s_d    = 1'b1;
    end
  end

  // State registers; reset to IDLE with B as last served so A wins first.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_B;
      s_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode directly from registers, so they are glitch-free.
  always_comb begin
    GNT_A    = (state_q == ST_OWN_A);
    GNT_B    = (state_q == ST_OWN_B);
    VALID    = GNT_A || GNT_B;
    S        = s_q;
    HOLD_CNT = cnt_q;
  end

endmodule

// File: tb/tb_mux2_arb_ctrl.sv
// Directed bench for mux2_arb_ctrl: default instance (MAX_HOLD=4) plus a
// MAX_HOLD=1 instance sharing clock and reset.
module tb_mux2_arb_ctrl;

  logic       CK;
  logic       RN;
  logic       REQ_A, REQ_B;
  logic       GNT_A, GNT_B, S, VALID;
  logic [2:0] HOLD_CNT;

  logic       req_a1, req_b1;
  logic       gnt_a1, gnt_b1, s1, valid1;
  logic [2:0] hold_cnt1;

  int n_cmp;
  int n_err;

  mux2_arb_ctrl #(.MAX_HOLD(4), .CNT_W(3)) u_dut (
    .CK(CK), .RN(RN), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B), .S(S), .VALID(VALID), .HOLD_CNT(HOLD_CNT)
  );

  mux2_arb_ctrl #(.MAX_HOLD(1), .CNT_W(3)) u_dut1 (
    .CK(CK), .RN(RN), .REQ_A(req_a1), .REQ_B(req_b1),
    .GNT_A(gnt_a1), .GNT_B(gnt_b1), .S(s1), .VALID(valid1), .HOLD_CNT(hold_cnt1)
  );

  // {GNT_A, GNT_B, S, VALID, HOLD_CNT}
  logic [6:0] obs;
  logic [6:0] obs1;
  assign obs  = {GNT_A, GNT_B, S, VALID, HOLD_CNT};
  assign obs1 = {gnt_a1, gnt_b1, s1, valid1, hold_cnt1};

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    RN = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; req_a1 = 1'b0; req_b1 = 1'b0;
    #3;
    exp = 7'b0000_000;
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_async: got %b required %b", obs, exp);
    end
    REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_held: got %b required %b", obs, exp);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    RN = 1'b1;
    tick();
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_idle: got %b required %b", obs, exp);
    end
  endtask

  task automatic test_single();
    logic [6:0] exp;
    REQ_A = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = {1'b1, 1'b0, 1'b0, 1'b1, (i < 3) ? 3'(i) : 3'd3};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL single_a[%0d]: got %b required %b", i, obs, exp);
      end
    end
    REQ_B = 1'b1;
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL saturated_switch: got %b required %b", obs, exp);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL idle_holds_s: got %b required %b", obs, exp);
    end
  endtask

  task automatic test_contention();
    logic [6:0] exp;
    logic       ga;
    RN = 1'b0;
    #2;
    RN = 1'b1;
    REQ_A = 1'b1; REQ_B = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      ga  = ((i / 4) % 2) == 0;
      exp = {ga, ~ga, ~ga, 1'b1, 3'(i % 4)};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL contention[%0d]: got %b required %b", i, obs, exp);
      end
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL contention_idle: got %b required %b", obs, exp);
    end
  endtask

  task automatic test_release();
    logic [6:0] exp;
    REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    tick();
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL release_pre: got %b required %b", obs, exp);
    end
    REQ_A = 1'b0;
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL release_handover: got %b required %b", obs, exp);
    end
    REQ_B = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [6:0] exp;
    REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL rr_after_b: got %b required %b", obs, exp);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL rr_idle_a: got %b required %b", obs, exp);
    end
    REQ_A = 1'b1; REQ_B = 1'b1;
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL rr_after_a: got %b required %b", obs, exp);
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    logic [6:0] exp;
    REQ_B = 1'b1;
    tick();
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 3'd1};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL mid_pre: got %b required %b", obs, exp);
    end
    #3;
    RN = 1'b0;
    #1;
    exp = 7'b0000_000;
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL mid_reset_async: got %b required %b", obs, exp);
    end
    tick();
    RN = 1'b1;
    #1;
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL mid_reset_no_early_grant: got %b required %b", obs, exp);
    end
    tick();
    exp = {1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL mid_regrant: got %b required %b", obs, exp);
    end
    REQ_B = 1'b0;
    tick();
  endtask

  task automatic test_max_hold_one();
    logic [6:0] exp;
    logic       ga;
    req_a1 = 1'b1; req_b1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      ga  = (i % 2) == 0;
      exp = {ga, ~ga, ~ga, 1'b1, 3'd0};
      n_cmp++;
      if (obs1 !== exp) begin
        n_err++; $display("FAIL max_hold_one[%0d]: got %b required %b", i, obs1, exp);
      end
    end
    req_a1 = 1'b0; req_b1 = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_contention();
    test_release();
    test_round_robin();
    test_reset_mid_grant();
    test_max_hold_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux2_arb_ctrl.md
# mux2_arb_ctrl

Round-robin arbiter and select controller that shares one MUX2_X1 datapath between two requesters, A and B. It takes per-requester requests, issues one-hot registered grants, and drives the mux select S so that mux output Z carries the granted requester's data. A hold counter bounds how long one requester can keep the mux while the other waits. The block sits directly in front of the MUX2_X1 select pin.

## Interface

Parameters:
- MAX_HOLD, default 4: maximum consecutive grant cycles for one owner while the other requester is waiting; legal range 1 to 2^CNT_W.
- CNT_W, default 3: width of the hold counter.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, asynchronous, active-low.
- REQ_A  input  1  request from requester A; level-sensitive.
- REQ_B  input  1  request from requester B; level-sensitive.
- GNT_A  output  1  grant to A; registered.
- GNT_B  output  1  grant to B; registered.
- S  output  1  mux select; registered. 0 selects A, 1 selects B.
- VALID  output  1  GNT_A | GNT_B; Z is meaningful when VALID is high.
- HOLD_CNT  output  CNT_W  cycles the current owner has held the grant, minus 1.

## Operation

- The state machine has three states: IDLE, OWN_A, OWN_B. GNT_A = (state == OWN_A). GNT_B = (state == OWN_B). GNT_A and GNT_B are never both 1.
- A LAST register records the most recently served requester. Reset value is B, so A wins the first contention.
- Transitions from IDLE:
  - REQ_A & REQ_B: go to the owner that is not LAST.
  - Only REQ_A: go to OWN_A.
  - Only REQ_B: go to OWN_B.
  - Neither: stay in IDLE.
- Transitions from OWN_A (OWN_B is symmetric):
  - REQ_A = 0 and REQ_B = 1: go to OWN_B.
  - REQ_A = 0 and REQ_B = 0: go to IDLE.
  - REQ_A = 1, REQ_B = 1 and HOLD_CNT == MAX_HOLD-1: go to OWN_B (preemption).
  - Otherwise: stay in OWN_A.
- Hold counter:
  - Loads 0 on any edge that enters OWN_A or OWN_B from a different state.
  - Increments by 1 each edge the state stays in the same OWN state.
  - Saturates at MAX_HOLD-1.
  - Is 0 while in IDLE.
- When MAX_HOLD = 1, contended ownership alternates every cycle.
- LAST updates on every edge that enters an OWN state.
- S register:
  - Set to 1 on entering OWN_B.
  - Cleared to 0 on entering OWN_A.
  - Holds its value in IDLE, so the select never toggles without a new grant.
- Uncontended owner: it keeps the grant indefinitely while the counter sits saturated. If the other requester then asserts, the switch happens on the next edge.
- A requester must hold REQ until it sees its grant. Dropping REQ before the grant is legal; that requester is then simply not granted.

## Timing

- Reset (RN = 0, asynchronous, no clock needed):
  - State = IDLE.
  - GNT_A = 0, GNT_B = 0, VALID = 0, S = 0, HOLD_CNT = 0, LAST = B.
- Reset asserted mid-grant clears the grants immediately. No grant is issued until the first rising edge after RN deasserts.
- Request-to-grant latency is 1 cycle: REQ sampled at edge N gives GNT at edge N.
- Owner-to-owner handover has zero bubble. GNT_A falls and GNT_B rises on the same edge, and S changes on that same edge.
- Under continuous contention, each owner holds the grant for exactly MAX_HOLD cycles.
- Z (combinational in MUX2_X1) is valid in the same cycle that VALID is high.

## Test plan

- Reset: drive RN = 0 at arbitrary times, including mid-OWN_B -> GNT_A = 0, GNT_B = 0, S = 0, HOLD_CNT = 0 immediately, without waiting for a clock edge.
- Single requester: REQ_A = 1 from cycle 0 -> GNT_A = 1 and S = 0 from cycle 1. HOLD_CNT counts 0, 1, 2, 3 and stays at 3 (MAX_HOLD = 4).
- Contention: REQ_A = 1 and REQ_B = 1 held continuously from IDLE after reset -> GNT_A for 4 cycles, then GNT_B for 4 cycles, repeating. S toggles on each handover with no idle cycle.
- Release handover: A owns, B waiting, REQ_A drops at cycle N -> GNT_B = 1, S = 1 at edge N+1. HOLD_CNT = 0 at that edge.
- Round-robin from IDLE: B served last, both go idle, then REQ_A and REQ_B rise together -> A is granted. Repeat after A is served last -> B is granted.
- MAX_HOLD = 1, both requests high -> grants alternate every cycle. VALID stays 1 throughout.
